// File: rtl/lab62soc_pio_pkg.sv
// lab62soc_pio_pkg
// Shared constants for the lab62soc input PIO: the register word addresses
// and the edge-type encodings used by the EDGE_TYPE parameter.
// No ports.

package lab62soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Warm-up counter value at which edge detection is enabled.
    localparam logic [1:0] WARM_DONE = 2'd2;

endpackage

// File: rtl/lab62soc_pio_sync.sv
// lab62soc_pio_sync
// Two-flop synchronizer for a WIDTH-bit asynchronous bus, a third delay
// stage for edge detection, a saturating warm-up counter that holds edge
// detection off after reset, and the edge detector itself.
//
// Ports:
//   clk_i      system clock
//   reset_i    synchronous, active-high reset
//   in_port_i  asynchronous input pins
//   level_o    synchronized level (s2)
//   edge_o     one-cycle edge pulse per bit, gated by warm-up

module lab62soc_pio_sync
    import lab62soc_pio_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] s3_d;
    logic [1:0]       warm_q, warm_d;
    logic             warm_done;
    logic [WIDTH-1:0] edge_raw;

    assign warm_done = (warm_q == WARM_DONE);
    assign warm_d    = warm_done ? warm_q : warm_q + 2'd1;

    // While warming up, s3 is primed from s1 so that by the time detection
    // turns on, s3 already equals s2. A pin held active through reset then
    // looks like a steady level rather than a fresh edge.
    assign s3_d = warm_done ? s2_q : s1_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            warm_q <= '0;
        end else begin
            s1_q   <= in_port_i;
            s2_q   <= s1_q;
            s3_q   <= s3_d;
            warm_q <= warm_d;
        end
    end

    always_comb begin
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_raw = ~s2_q & s3_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_raw = s2_q ^ s3_q;
        end else begin
            edge_raw = s2_q & ~s3_q;
        end
    end

    assign edge_o  = warm_done ? edge_raw : '0;
    assign level_o = s2_q;

endmodule

// File: rtl/lab62soc_pio_in.sv
// lab62soc_pio_in
// Avalon-MM slave input PIO. Synchronizes a WIDTH-bit input bus, exposes
// the level, records edges in a sticky write-1-to-clear capture register
// and drives a maskable level interrupt.
//
// Compile-time option: define PIO_IN_IRQ_EN to build the IRQ_MASK register
// and irq logic. Without it, address 2 reads 0, writes to it are ignored
// and irq is tied low.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register word select (DATA, DIRECTION, IRQ_MASK, EDGE_CAPTURE)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, only [WIDTH-1:0] used
//   readdata    read data, zero-extended, zero-latency
//   in_port     asynchronous input pins
//   irq         level interrupt to CPU

module lab62soc_pio_in
    import lab62soc_pio_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] mask_rd;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    lab62soc_pio_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .clk_i     (clk),
        .reset_i   (reset),
        .in_port_i (in_port),
        .level_o   (level),
        .edge_o    (edge_pulse)
    );

    // Set is OR-ed in after the clear so a new edge wins over a W1C
    // landing on the same bit in the same cycle.
    assign w1c        = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign edge_cap_d = (edge_cap_q & ~w1c) | edge_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cap_q <= '0;
        end else begin
            edge_cap_q <= edge_cap_d;
        end
    end

`ifdef PIO_IN_IRQ_EN
    logic [WIDTH-1:0] mask_q, mask_d;

    assign mask_d = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_rd = mask_q;
    assign irq     = |(edge_cap_q & mask_q);
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = level;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_rd;
            ADDR_EDGE: readdata[WIDTH-1:0] = edge_cap_q;
            default:   readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_lab62soc_pio_in.sv
// tb_lab62soc_pio_in
// Directed bench for lab62soc_pio_in (WIDTH=4, rising edges). Each read
// pushes the hand-computed readdata/irq pair into a queue; a monitor on the
// falling clock edge pops and compares whenever a read is presented.
// Expectations for IRQ_MASK and irq follow PIO_IN_IRQ_EN.

module tb_lab62soc_pio_in;

`ifdef PIO_IN_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    lab62soc_pio_in #(
        .WIDTH     (4),
        .EDGE_TYPE (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] m(input logic [31:0] v);
        return IRQ_EN ? v : 32'd0;
    endfunction

    function automatic logic mi(input logic v);
        return IRQ_EN ? v : 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic i, input string n);
        exp_t e;
        e.name = n;
        e.data = d;
        e.irq  = i;
        exp_q.push_back(e);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    always @(negedge clk) begin
        if (chipselect && write_n) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: readdata=%h with no expectation queued", readdata);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (readdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL %s data: got %h expected %h", mon_e.name, readdata, mon_e.data);
                end
                checks++;
                if (irq !== mon_e.irq) begin
                    errors++;
                    $display("FAIL %s irq: got %b expected %b", mon_e.name, irq, mon_e.irq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'b0101;
        repeat (3) tick();

        // Reset state, pin already high
        rd(2'd0, 32'd0, 1'b0, "rst_data");
        rd(2'd1, 32'd0, 1'b0, "rst_dir");
        rd(2'd2, 32'd0, 1'b0, "rst_mask");
        rd(2'd3, 32'd0, 1'b0, "rst_edge");

        // Pin held high through reset release: level shows, no capture
        reset = 1'b0;
        tick();
        tick();
        rd(2'd0, 32'd5, 1'b0, "warm_data");
        rd(2'd3, 32'd0, 1'b0, "warm_edge0");
        repeat (4) tick();
        rd(2'd3, 32'd0, 1'b0, "warm_edge1");

        // Falling edges ignored for rising-edge build
        in_port = 4'b0000;
        repeat (4) tick();
        rd(2'd3, 32'd0, 1'b0, "fall_ignored");
        wr(2'd2, 32'h0000_0002, 1'b1);
        rd(2'd2, m(32'd2), 1'b0, "mask_rd2");

        // Rising edge on bit 1: DATA after E1, capture + irq after E2
        in_port = 4'b0010;
        tick();
        tick();
        rd(2'd0, 32'd2, 1'b0, "rise_data_e1");
        rd(2'd3, 32'd2, mi(1'b1), "rise_edge_e2");

        // W1C clears capture and irq
        wr(2'd3, 32'h0000_0002, 1'b1);
        rd(2'd3, 32'd0, 1'b0, "w1c_clear");

        // W1C on the same edge as a new capture: set wins
        in_port = 4'b0000;
        repeat (4) tick();
        in_port = 4'b0010;
        tick();
        tick();
        wr(2'd3, 32'h0000_0002, 1'b1);
        rd(2'd3, 32'd2, mi(1'b1), "set_wins");

        // Write without chipselect is ignored
        wr(2'd3, 32'h0000_000F, 1'b0);
        rd(2'd3, 32'd2, mi(1'b1), "no_cs_write");
        wr(2'd3, 32'hFFFF_FFFF, 1'b1);
        rd(2'd3, 32'd0, 1'b0, "w1c_all");

        // Capture on bit 3 while masked off, then unmask
        wr(2'd2, 32'h0000_0000, 1'b1);
        in_port = 4'b1010;
        repeat (4) tick();
        rd(2'd3, 32'd8, 1'b0, "masked_off");
        wr(2'd2, 32'hFFFF_FFF8, 1'b1);
        rd(2'd2, m(32'd8), mi(1'b1), "unmask_irq");
        wr(2'd1, 32'hFFFF_FFFF, 1'b1);
        rd(2'd1, 32'd0, mi(1'b1), "dir_ro");

        // One-cycle reset mid-operation clears everything
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(2'd0, 32'd0, 1'b0, "mid_rst_data");
        rd(2'd3, 32'd0, 1'b0, "mid_rst_edge");
        rd(2'd2, 32'd0, 1'b0, "mid_rst_mask");
        repeat (6) tick();
        rd(2'd0, 32'd10, 1'b0, "post_rst_data");
        rd(2'd3, 32'd0, 1'b0, "post_rst_edge");

        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d reads left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
